// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - fetch-side bus between the PC unit and instruction memory / D stage
//
// Purpose: groups the fetch request/response handshake and the F-stage status
//          signals produced by fetch_pc_unit.
// Signals:
//   imem_req   master->slave  fetch request for f_pc
//   imem_ready slave->master  IM returns the instruction at f_pc this cycle
//   f_pc       master->slave  current fetch PC
//   f_valid    master->slave  instruction at f_pc completes this cycle
//   f_adel     master->slave  fetch address error (misaligned or out of IM range)
//   f_bd       master->slave  instruction in F is a branch delay slot
interface fetch_pc_unit_if;
   logic        imem_req;
   logic        imem_ready;
   logic [31:0] f_pc;
   logic        f_valid;
   logic        f_adel;
   logic        f_bd;

   modport master (
      output imem_req,
      output f_pc,
      output f_valid,
      output f_adel,
      output f_bd,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  f_pc,
      input  f_valid,
      input  f_adel,
      input  f_bd,
      output imem_ready
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - F-stage PC register and next-PC logic with one-slot delayed redirect
//
// Purpose: owns the fetch PC, applies branch/jump/jr redirects decoded in D after
//          exactly one delay-slot fetch, holds a pending target while IM is slow,
//          handles CP0 flush (req) and eret, and flags AdEL on illegal fetch PCs.
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   stall               hazard stall of F/D
//   d_pc, d_imm16,
//   d_imm26, d_rs       D-stage operands for target computation
//   d_branch, d_jump,
//   d_jr, cmp           D-stage control-transfer decode and branch outcome
//   req                 exception/interrupt flush from CP0
//   eret, epc           exception return and its target
//   bus (master)        imem_req/imem_ready handshake, f_pc, f_valid, f_adel, f_bd
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] IM_LO      = 32'h0000_3000,
   parameter logic [31:0] IM_HI      = 32'h0000_6ffc
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic [31:0]            d_pc,
   input  logic [15:0]            d_imm16,
   input  logic [25:0]            d_imm26,
   input  logic [31:0]            d_rs,
   input  logic                   d_branch,
   input  logic                   d_jump,
   input  logic                   d_jr,
   input  logic                   cmp,
   input  logic                   req,
   input  logic                   eret,
   input  logic [31:0]            epc,
   fetch_pc_unit_if.master        bus
);

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_t;

   state_t      state_q, state_nxt;
   logic [31:0] f_pc_q, pc_nxt;
   logic [31:0] tgt_q, tgt_nxt;

   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] target;
   logic        redir;
   logic        adel;
   logic        done;

   assign br_tgt = d_pc + 32'd4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
   assign j_tgt  = {d_pc[31:28], d_imm26, 2'b00};
   // Decode is one-hot; the ordering only matters if decode misbehaves.
   assign target = d_jr ? d_rs : (d_jump ? j_tgt : br_tgt);
   assign redir  = (d_branch & cmp) | d_jump | d_jr;

   assign adel = (f_pc_q[1:0] != 2'b00) | (f_pc_q < IM_LO) | (f_pc_q > IM_HI);
   // A faulting fetch never goes to IM, so it completes on its own.
   assign done = (bus.imem_ready | adel) & ~stall;

   assign bus.f_pc     = f_pc_q;
   assign bus.f_adel   = adel;
   assign bus.imem_req = ~adel;
   assign bus.f_valid  = bus.imem_ready | adel;
   assign bus.f_bd     = ~req & ((state_q == PEND) |
                                 ((state_q == RUN) & (d_branch | d_jump | d_jr)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         f_pc_q  <= RESET_PC;
         tgt_q   <= '0;
      end else begin
         state_q <= state_nxt;
         f_pc_q  <= pc_nxt;
         tgt_q   <= tgt_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      pc_nxt    = f_pc_q;
      tgt_nxt   = tgt_q;
      if (req) begin
         pc_nxt    = HANDLER_PC;
         state_nxt = RUN;
         tgt_nxt   = '0;
      end else if (eret && !stall) begin
         pc_nxt    = epc;
         state_nxt = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (redir && !stall) begin
                  if (done) begin
                     // Slot completes now; the target is the next fetch.
                     pc_nxt = target;
                  end else begin
                     // Slot still fetching: remember the target, D moves on.
                     tgt_nxt   = target;
                     state_nxt = PEND;
                  end
               end else if (done) begin
                  pc_nxt = f_pc_q + 32'd4;
               end
            end
            PEND: begin
               if (done) begin
                  pc_nxt    = tgt_q;
                  state_nxt = RUN;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit with a queue-based fetch model
module tb_fetch_pc_unit;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [31:0] d_pc;
   logic [15:0] d_imm16;
   logic [25:0] d_imm26;
   logic [31:0] d_rs;
   logic        d_branch, d_jump, d_jr, cmp, req, eret;
   logic [31:0] epc;

   fetch_pc_unit_if bus ();

   fetch_pc_unit dut (
      .clk      (clk),
      .reset    (reset),
      .stall    (stall),
      .d_pc     (d_pc),
      .d_imm16  (d_imm16),
      .d_imm26  (d_imm26),
      .d_rs     (d_rs),
      .d_branch (d_branch),
      .d_jump   (d_jump),
      .d_jr     (d_jr),
      .cmp      (cmp),
      .req      (req),
      .eret     (eret),
      .epc      (epc),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: the PC plus a queue of redirect targets that must follow the
   // current (delay-slot) fetch.
   logic [31:0] m_pc;
   logic [31:0] m_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   task automatic set_idle();
      stall = 0; d_pc = 0; d_imm16 = 0; d_imm26 = 0; d_rs = 0;
      d_branch = 0; d_jump = 0; d_jr = 0; cmp = 0; req = 0; eret = 0; epc = 0;
   endtask

   task automatic model_reset();
      m_pc = RESET_PC;
      m_q.delete();
   endtask

   function automatic logic model_adel(input logic [31:0] pc);
      return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6ffc);
   endfunction

   function automatic logic [31:0] model_target();
      logic signed [31:0] off;
      off = $signed(d_imm16);
      off = off * 4;
      if (d_jr) return d_rs;
      if (d_jump) return (d_pc & 32'hF000_0000) | ({6'd0, d_imm26} * 4);
      return d_pc + 32'd4 + off;
   endfunction

   task automatic compare_model();
      logic adel;
      logic bd;
      adel = model_adel(m_pc);
      bd   = !req && (m_q.size() > 0 || d_branch || d_jump || d_jr);
      check("f_pc", bus.f_pc, m_pc);
      check("f_adel", {31'd0, bus.f_adel}, {31'd0, adel});
      check("imem_req", {31'd0, bus.imem_req}, {31'd0, !adel});
      check("f_valid", {31'd0, bus.f_valid}, {31'd0, bus.imem_ready | adel});
      check("f_bd", {31'd0, bus.f_bd}, {31'd0, bd});
   endtask

   task automatic model_advance();
      logic complete;
      complete = (bus.imem_ready || model_adel(m_pc)) && !stall;
      if (req) begin
         m_pc = HANDLER_PC;
         m_q.delete();
      end else if (eret && !stall) begin
         m_pc = epc;
         m_q.delete();
      end else begin
         if (!stall && m_q.size() == 0 && ((d_branch && cmp) || d_jump || d_jr))
            m_q.push_back(model_target());
         if (complete)
            m_pc = (m_q.size() > 0) ? m_q.pop_front() : m_pc + 32'd4;
      end
   endtask

   // Entered just after a falling edge with inputs applied; returns after the next falling edge.
   task automatic cycle();
      #1;
      compare_model();
      model_advance();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_jr(input logic [31:0] tgt, input logic rdy);
      set_idle();
      d_jr = 1; d_rs = tgt;
      bus.imem_ready = rdy;
   endtask

   initial begin
      set_idle();
      reset = 0;
      bus.imem_ready = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      check("reset f_pc", bus.f_pc, 32'h3000);
      check("reset imem_req", {31'd0, bus.imem_req}, 32'd1);
      check("reset f_bd", {31'd0, bus.f_bd}, 32'd0);
      @(negedge clk);
      reset = 1;
      bus.imem_ready = 1;

      // Sequential fetch after reset.
      cycle();
      check("seq1", bus.f_pc, 32'h3004);

      // beq at d_pc=0x3000 offset -1: not taken then taken.
      set_idle(); d_pc = 32'h3000; d_imm16 = 16'hFFFF; d_branch = 1; cmp = 0;
      bus.imem_ready = 1;
      cycle();
      check("br not taken", bus.f_pc, 32'h3008);
      cmp = 1;
      cycle();
      check("br taken", bus.f_pc, 32'h3000);
      set_idle();
      cycle();
      check("seq after br", bus.f_pc, 32'h3004);

      // jr to 0x3400 while IM is slow: pending redirect.
      drive_jr(32'h3400, 0);
      cycle();
      check("jr pend hold", bus.f_pc, 32'h3004);
      set_idle(); bus.imem_ready = 0;
      #1;
      check("pend f_bd", {31'd0, bus.f_bd}, 32'd1);
      cycle();
      check("pend hold2", bus.f_pc, 32'h3004);
      bus.imem_ready = 1;
      cycle();
      check("pend land", bus.f_pc, 32'h3400);

      // req during PEND with stall: handler wins, pending target dropped.
      drive_jr(32'h3500, 0);
      cycle();
      set_idle(); req = 1; stall = 1; bus.imem_ready = 0;
      #1;
      check("req f_bd", {31'd0, bus.f_bd}, 32'd0);
      cycle();
      check("req handler", bus.f_pc, HANDLER_PC);
      set_idle(); bus.imem_ready = 1;
      cycle();
      check("req no tgt", bus.f_pc, 32'h4184);

      // Misaligned fetch via jr.
      drive_jr(32'h3002, 1);
      cycle();
      check("jr misaligned", bus.f_pc, 32'h3002);
      set_idle(); bus.imem_ready = 0;
      #1;
      check("mis adel", {31'd0, bus.f_adel}, 32'd1);
      check("mis imem_req", {31'd0, bus.imem_req}, 32'd0);
      check("mis f_valid", {31'd0, bus.f_valid}, 32'd1);
      cycle();
      check("mis advance", bus.f_pc, 32'h3006);

      // Upper bound: 0x6ffc legal, 0x7000 faults.
      drive_jr(32'h6ffc, 1);
      cycle();
      set_idle(); bus.imem_ready = 1;
      #1;
      check("hi legal", {31'd0, bus.f_adel}, 32'd0);
      cycle();
      check("hi step", bus.f_pc, 32'h7000);
      bus.imem_ready = 0;
      #1;
      check("hi adel", {31'd0, bus.f_adel}, 32'd1);
      check("hi f_valid", {31'd0, bus.f_valid}, 32'd1);
      cycle();

      // eret held by stall, then taken.
      set_idle(); eret = 1; epc = 32'h3010; stall = 1; bus.imem_ready = 1;
      cycle();
      check("eret stalled", bus.f_pc, 32'h7004);
      stall = 0;
      cycle();
      check("eret taken", bus.f_pc, 32'h3010);

      // Reset asserted while a redirect is pending.
      drive_jr(32'h3500, 0);
      cycle();
      set_idle();
      reset = 0;
      #1;
      check("async reset", bus.f_pc, RESET_PC);
      model_reset();
      @(negedge clk);
      reset = 1;
      bus.imem_ready = 1;
      cycle();
      check("reset drops tgt", bus.f_pc, 32'h3004);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         int kind;
         set_idle();
         stall          = ($urandom % 4) == 0;
         bus.imem_ready = ($urandom % 3) != 0;
         kind           = $urandom % 6;
         d_pc           = bus.f_pc - 32'd4;
         d_imm16        = 16'($urandom);
         d_imm26        = 26'($urandom);
         cmp            = 1'($urandom);
         d_rs           = (($urandom % 8) == 0) ? $urandom
                                                : 32'h3000 + ($urandom_range(0, 16'h0fff) * 4);
         d_branch       = (kind == 1) || (kind == 4);
         d_jump         = (kind == 2);
         d_jr           = (kind == 3);
         req            = ($urandom % 40) == 0;
         eret           = ($urandom % 30) == 0;
         epc            = 32'h3000 + ($urandom_range(0, 16'h0fff) * 4);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
